// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   - SEG_A..SEG_G, SEG_DP : bit positions inside an 8-bit segment word
//                            laid out as {dp,g,f,e,d,c,b,a}
//   - SEG_W                : width of a segment word
//   - GLYPH_TBL            : 16-entry hex glyph table, each entry gfedcba
//                            (bit k drives segment k, bit 0 = a)
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned NIB_W   = 4;

    // Standard hex glyphs 0-9, A, b, C, d, E, F (active-high, gfedcba)
    localparam logic [GLYPH_W-1:0] GLYPH_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage : seg7_pkg

// File: rtl/seg7_hex_lut.sv
// ---------------------------------------------------------------------------
// seg7_hex_lut
// Combinational nibble-to-glyph decode for one digit.
// Ports:
//   nibble_i  [3:0] : hex value to show
//   dp_i            : decimal point for this digit
//   blank_i         : suppress the whole digit (segments and dp off)
//   glyph_c_o [7:0] : {dp,g,f,e,d,c,b,a}, active-high, unregistered
// ---------------------------------------------------------------------------
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             dp_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] glyph_c_o
);

    logic [GLYPH_W-1:0] raw;

    // Table lookup, then scatter into the named segment positions
    always_comb begin
        raw       = GLYPH_TBL[nibble_i];
        glyph_c_o = '0;
        if (!blank_i) begin
            glyph_c_o[SEG_A]  = raw[0];
            glyph_c_o[SEG_B]  = raw[1];
            glyph_c_o[SEG_C]  = raw[2];
            glyph_c_o[SEG_D]  = raw[3];
            glyph_c_o[SEG_E]  = raw[4];
            glyph_c_o[SEG_F]  = raw[5];
            glyph_c_o[SEG_G]  = raw[6];
            glyph_c_o[SEG_DP] = dp_i;
        end
    end

endmodule : seg7_hex_lut

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-pin seven-segment digits.
// Each digit owns a slot of DWELL clocks; the first GUARD clocks of a slot
// keep every digit off so segment lines can settle without ghosting.
// New data is captured into a shadow register on load_i and only becomes
// visible at the frame boundary, so a frame never shows a torn value.
//
// Parameters:
//   NUM_DIGITS (1..8), CLK_HZ, REFRESH_HZ, GUARD, ACTIVE_LOW (pin inversion)
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   data_i          : 4*NUM_DIGITS hex nibbles, digit 0 in the LSBs
//   dp_i            : decimal point per digit
//   load_i          : one-cycle capture request for data_i/dp_i
//   blank_i         : force all digits off while high
//   seg_o [7:0]     : {dp,g,f,e,d,c,b,a}, registered
//   dig_o           : one-hot digit enable, registered
//   pending_o       : a captured value is waiting for the frame boundary
//   frame_o         : one-cycle pulse when the last digit slot ends
// Build option:
//   SEG7_LZ_BLANK_EN : blank leading zero digits (digit 0 always shown)
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned REFRESH_HZ = 100,
    parameter int unsigned GUARD      = 4,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    input  logic                    blank_i,
    output logic [SEG_W-1:0]        seg_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    pending_o,
    output logic                    frame_o
);

    localparam int unsigned DWELL  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;
    // Segment reload window: strictly inside the guard, one count after the
    // previous digit went dark, so seg_o never moves while a digit is lit.
    localparam int unsigned SEG_LD_LO = (GUARD >= 2) ? 1 : 0;
    localparam int unsigned SEG_LD_HI = (GUARD >= 1) ? GUARD : 1;

    // Elaboration-time parameter checks
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (DWELL < GUARD + 2) begin : g_bad_dwell
        $error("seg7_scan_driver: DWELL must be at least GUARD+2");
    end

    // State
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q,   shadow_dp_d;
    logic [DATA_W-1:0]     disp_data_q,   disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,     disp_dp_d;
    logic                  pending_q,     pending_d;
    logic                  frame_q,       frame_d;
    logic [SEG_W-1:0]      seg_q,         seg_d;
    logic [NUM_DIGITS-1:0] dig_q,         dig_d;

    // Combinational helpers
    logic                  slot_end;
    logic                  frame_end;
    logic                  dig_on;
    logic                  seg_ld;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NIB_W-1:0]      cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [SEG_W-1:0]      glyph;

    assign slot_end  = (cnt_q == CNT_W'(DWELL - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG7_LZ_BLANK_EN
    // Walk from the top digit down; a digit is blanked while every digit at
    // or above it is zero. Digit 0 is never part of the mask.
    always_comb begin : lz_scan
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_data_q[NIB_W*i +: NIB_W] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the nibble, dp and blank flag of the digit owning this slot
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = disp_data_q[NIB_W*i +: NIB_W];
                cur_dp  = disp_dp_q[i];
                cur_lz  = lz_mask[i];
            end
        end
    end

    seg7_hex_lut u_lut (
        .nibble_i  (cur_nib),
        .dp_i      (cur_dp),
        .blank_i   (cur_lz),
        .glyph_c_o (glyph)
    );

    // Next-state: slot/digit counters, shadow handshake, output registers
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        pending_d     = pending_q;
        frame_d       = 1'b0;
        seg_d         = seg_q;
        dig_d         = '0;
        dig_on        = 1'b0;
        seg_ld        = 1'b0;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Newest load always wins the shadow
        if (load_i) begin
            shadow_data_d = data_i;
            shadow_dp_d   = dp_i;
            pending_d     = 1'b1;
        end

        // Boundary transfer uses the pre-load shadow; a coincident load
        // stays pending for the following boundary.
        if (frame_end) begin
            disp_data_d = shadow_data_q;
            disp_dp_d   = shadow_dp_q;
            pending_d   = load_i;
            frame_d     = 1'b1;
        end

        dig_on = (cnt_q >= CNT_W'(GUARD)) && !blank_i;
        if (dig_on) begin
            dig_d = NUM_DIGITS'(1) << idx_q;
        end

        seg_ld = (cnt_q >= CNT_W'(SEG_LD_LO)) && (cnt_q < CNT_W'(SEG_LD_HI));
        if (blank_i) begin
            seg_d = '0;
        end else if (seg_ld) begin
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= '0;
            dig_q         <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            frame_q       <= frame_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
        end
    end

    // With a single digit the index register can never leave 0
    if (NUM_DIGITS == 1) begin : g_single_digit
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (idx_q == '0) else $error("seg7_scan_driver: digit index left 0");
            end
        end
    end

    // Pin polarity; the registers hold active-high values
    assign seg_o     = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dig_o     = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;
    assign pending_o = pending_q;
    assign frame_o   = frame_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver at NUM_DIGITS=2, CLK_HZ=1000,
// REFRESH_HZ=50, GUARD=2 (DWELL=10, frame = 20 clocks). A second instance
// with ACTIVE_LOW=1 shares every input to check the pin polarity.
// Step s counts clock edges after reset release, starting at 1.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [7:0] ZERO_HI = 8'h00;
`else
    localparam logic [7:0] ZERO_HI = 8'h3F;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_i;
    logic [1:0] dp_i;
    logic       load_i;
    logic       blank_i;

    logic [7:0] seg_o,     seg_al_o;
    logic [1:0] dig_o,     dig_al_o;
    logic       pending_o, pending_al_o;
    logic       frame_o,   frame_al_o;

    int n_checks = 0;
    int n_fail   = 0;
    int s        = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (2), .CLK_HZ (1000), .REFRESH_HZ (50), .GUARD (2), .ACTIVE_LOW (0)
    ) dut (
        .clk (clk), .reset (reset), .data_i (data_i), .dp_i (dp_i),
        .load_i (load_i), .blank_i (blank_i), .seg_o (seg_o), .dig_o (dig_o),
        .pending_o (pending_o), .frame_o (frame_o)
    );

    seg7_scan_driver #(
        .NUM_DIGITS (2), .CLK_HZ (1000), .REFRESH_HZ (50), .GUARD (2), .ACTIVE_LOW (1)
    ) dut_al (
        .clk (clk), .reset (reset), .data_i (data_i), .dp_i (dp_i),
        .load_i (load_i), .blank_i (blank_i), .seg_o (seg_al_o), .dig_o (dig_al_o),
        .pending_o (pending_al_o), .frame_o (frame_al_o)
    );

    // Expected active-high digit enable for step s in an unblanked frame
    function automatic logic [1:0] exp_dig(input int st);
        int p;
        p = (st - 1) % 20;
        if (p < 2)  return 2'b00;
        if (p < 10) return 2'b01;
        if (p < 12) return 2'b00;
        return 2'b10;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        s++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        load_i  = 1'b0;
        blank_i = 1'b0;
        data_i  = 8'h00;
        dp_i    = 2'b00;
        repeat (3) step();
        reset = 1'b0;
        s     = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        blank_i = 1'b0;
        data_i  = 8'hFF;
        dp_i    = 2'b11;
        load_i  = 1'b1;
        repeat (3) step();
        n_checks++; if (dig_o !== 2'b00)     begin n_fail++; $display("FAIL reset_dig got %b exp 00", dig_o); end
        n_checks++; if (seg_o !== 8'h00)     begin n_fail++; $display("FAIL reset_seg got %h exp 00", seg_o); end
        n_checks++; if (pending_o !== 1'b0)  begin n_fail++; $display("FAIL reset_pending got %b exp 0", pending_o); end
        n_checks++; if (frame_o !== 1'b0)    begin n_fail++; $display("FAIL reset_frame got %b exp 0", frame_o); end
        n_checks++; if (dig_al_o !== 2'b11)  begin n_fail++; $display("FAIL reset_dig_al got %b exp 11", dig_al_o); end
        n_checks++; if (seg_al_o !== 8'hFF)  begin n_fail++; $display("FAIL reset_seg_al got %h exp ff", seg_al_o); end
        n_checks++; if (pending_al_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending_al got %b exp 0", pending_al_o); end
        load_i = 1'b0;
    endtask

    task automatic test_scan_timing();
        do_reset();
        while (s < 40) begin
            step();
            n_checks++; if (dig_o !== exp_dig(s)) begin n_fail++; $display("FAIL scan_dig s=%0d got %b exp %b", s, dig_o, exp_dig(s)); end
            n_checks++; if (frame_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL scan_frame s=%0d got %b", s, frame_o); end
            n_checks++; if (frame_al_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL scan_frame_al s=%0d got %b", s, frame_al_o); end
        end
    endtask

    task automatic test_load();
        logic [1:0] ed;
        do_reset();
        while (s < 40) begin
            load_i = (s == 4);
            data_i = (s == 4) ? 8'hA1 : 8'h00;
            dp_i   = (s == 4) ? 2'b01 : 2'b00;
            step();
            ed = exp_dig(s);
            n_checks++; if (pending_o !== (s >= 5 && s <= 19)) begin n_fail++; $display("FAIL load_pending s=%0d got %b", s, pending_o); end
            n_checks++; if (frame_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL load_frame s=%0d got %b", s, frame_o); end
            if (s >= 21 && ed == 2'b01) begin
                n_checks++; if (seg_o !== 8'h86) begin n_fail++; $display("FAIL load_seg_d0 s=%0d got %h exp 86", s, seg_o); end
            end
            if (s >= 21 && ed == 2'b10) begin
                n_checks++; if (seg_o !== 8'h77) begin n_fail++; $display("FAIL load_seg_d1 s=%0d got %h exp 77", s, seg_o); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_overwrite();
        logic [1:0] ed;
        do_reset();
        while (s < 60) begin
            load_i = (s == 2) || (s == 8);
            data_i = (s == 2) ? 8'h12 : ((s == 8) ? 8'h34 : 8'h00);
            dp_i   = 2'b00;
            step();
            ed = exp_dig(s);
            n_checks++; if (pending_o !== (s >= 3 && s <= 19)) begin n_fail++; $display("FAIL ovw_pending s=%0d got %b", s, pending_o); end
            if (s >= 21 && ed == 2'b01) begin
                n_checks++; if (seg_o !== 8'h66) begin n_fail++; $display("FAIL ovw_seg_d0 s=%0d got %h exp 66", s, seg_o); end
            end
            if (s >= 21 && ed == 2'b10) begin
                n_checks++; if (seg_o !== 8'h4F) begin n_fail++; $display("FAIL ovw_seg_d1 s=%0d got %h exp 4f", s, seg_o); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_boundary_load();
        logic [1:0] ed;
        logic [7:0] e0, e1;
        logic       ep;
        do_reset();
        while (s < 80) begin
            load_i = (s == 4) || (s == 39);
            data_i = (s == 4) ? 8'h56 : ((s == 39) ? 8'h78 : 8'h00);
            dp_i   = 2'b00;
            step();
            ed = exp_dig(s);
            ep = (s >= 5 && s <= 19) || (s >= 40 && s <= 59);
            n_checks++; if (pending_o !== ep) begin n_fail++; $display("FAIL bnd_pending s=%0d got %b exp %b", s, pending_o, ep); end
            n_checks++; if (frame_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL bnd_frame s=%0d got %b", s, frame_o); end
            e0 = (s > 60) ? 8'h7F : 8'h7D;
            e1 = (s > 60) ? 8'h07 : 8'h6D;
            if (s >= 21 && ed == 2'b01) begin
                n_checks++; if (seg_o !== e0) begin n_fail++; $display("FAIL bnd_seg_d0 s=%0d got %h exp %h", s, seg_o, e0); end
            end
            if (s >= 21 && ed == 2'b10) begin
                n_checks++; if (seg_o !== e1) begin n_fail++; $display("FAIL bnd_seg_d1 s=%0d got %h exp %h", s, seg_o, e1); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_blank();
        logic inb;
        do_reset();
        while (s < 60) begin
            blank_i = (s >= 4 && s <= 33);
            step();
            inb = (s >= 5 && s <= 34);
            n_checks++; if (frame_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL blank_frame s=%0d got %b", s, frame_o); end
            if (inb) begin
                n_checks++; if (dig_o !== 2'b00)    begin n_fail++; $display("FAIL blank_dig s=%0d got %b exp 00", s, dig_o); end
                n_checks++; if (seg_o !== 8'h00)    begin n_fail++; $display("FAIL blank_seg s=%0d got %h exp 00", s, seg_o); end
                n_checks++; if (dig_al_o !== 2'b11) begin n_fail++; $display("FAIL blank_dig_al s=%0d got %b exp 11", s, dig_al_o); end
                n_checks++; if (seg_al_o !== 8'hFF) begin n_fail++; $display("FAIL blank_seg_al s=%0d got %h exp ff", s, seg_al_o); end
            end else begin
                n_checks++; if (dig_o !== exp_dig(s)) begin n_fail++; $display("FAIL blank_scan s=%0d got %b exp %b", s, dig_o, exp_dig(s)); end
                n_checks++; if (dig_al_o !== ~exp_dig(s)) begin n_fail++; $display("FAIL blank_scan_al s=%0d got %b", s, dig_al_o); end
            end
        end
        blank_i = 1'b0;
    endtask

    task automatic test_lz();
        logic [1:0] ed;
        do_reset();
        while (s < 40) begin
            load_i = (s == 2);
            data_i = (s == 2) ? 8'h05 : 8'h00;
            dp_i   = 2'b00;
            step();
            ed = exp_dig(s);
            n_checks++; if (dig_o !== ed) begin n_fail++; $display("FAIL lz_dig s=%0d got %b exp %b", s, dig_o, ed); end
            if (s >= 21 && ed == 2'b01) begin
                n_checks++; if (seg_o !== 8'h6D) begin n_fail++; $display("FAIL lz_seg_d0 s=%0d got %h exp 6d", s, seg_o); end
            end
            if (s >= 21 && ed == 2'b10) begin
                n_checks++; if (seg_o !== ZERO_HI) begin n_fail++; $display("FAIL lz_seg_d1 s=%0d got %h exp %h", s, seg_o, ZERO_HI); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_reset_mid_pending();
        logic [1:0] ed;
        do_reset();
        while (s < 9) begin
            load_i = (s == 4);
            data_i = 8'h99;
            dp_i   = 2'b11;
            step();
        end
        load_i = 1'b0;
        n_checks++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending_before got %b exp 1", pending_o); end
        reset = 1'b1;
        step();
        step();
        n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending_in got %b exp 0", pending_o); end
        n_checks++; if (dig_o !== 2'b00)    begin n_fail++; $display("FAIL rstmid_dig_in got %b exp 00", dig_o); end
        reset = 1'b0;
        s     = 0;
        while (s < 40) begin
            step();
            ed = exp_dig(s);
            n_checks++; if (dig_o !== ed) begin n_fail++; $display("FAIL rstmid_dig s=%0d got %b exp %b", s, dig_o, ed); end
            n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending s=%0d got %b exp 0", s, pending_o); end
            n_checks++; if (frame_o !== (s % 20 == 0)) begin n_fail++; $display("FAIL rstmid_frame s=%0d got %b", s, frame_o); end
            if (ed == 2'b01) begin
                n_checks++; if (seg_o !== 8'h3F) begin n_fail++; $display("FAIL rstmid_seg_d0 s=%0d got %h exp 3f", s, seg_o); end
            end
            if (ed == 2'b10) begin
                n_checks++; if (seg_o !== ZERO_HI) begin n_fail++; $display("FAIL rstmid_seg_d1 s=%0d got %h exp %h", s, seg_o, ZERO_HI); end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        load_i  = 1'b0;
        blank_i = 1'b0;
        data_i  = 8'h00;
        dp_i    = 2'b00;
        test_reset();
        test_scan_timing();
        test_load();
        test_overwrite();
        test_boundary_load();
        test_blank();
        test_lz();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_driver
